io_in_reader: RTL

Memory-mapped input peripheral: the read-side counterpart of the seg7 output path. It synchronises and debounces the board switches and push-buttons, captures button press events in a sticky clear-on-read register, and returns register contents to the CPU load path when the address decoder asserts its chip-select. It sits beside `seg7x16` on the I/O bus and feeds the load-data mux ahead of `EXT_CUT`.

---
 rtl/io_pkg.sv | 8 +
 rtl/io_in_reader_if.sv | 10 +
 rtl/io_in_reader_debounce.sv | 34 +++
 rtl/io_in_reader.sv | 56 +++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared I/O register offsets and the I/O window base address.
package io_pkg;
    localparam logic [1:0]  IO_OFF_SW   = 2'd0;
    localparam logic [1:0]  IO_OFF_BTN  = 2'd1;
    localparam logic [1:0]  IO_OFF_EVT  = 2'd2;
    localparam logic [1:0]  IO_OFF_STAT = 2'd3;
    localparam logic [31:0] IO_BASE     = 32'hFFFF_F000;
endpackage

// File: rtl/io_in_reader_if.sv
// io_in_reader_if: CPU load-side bus between the address decoder and the input peripheral.
interface io_in_reader_if;
    logic        cs;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        evt_irq;
    modport master (output cs, rd, addr, input rdata, evt_irq);
    modport slave  (input cs, rd, addr, output rdata, evt_irq);
endinterface

// File: rtl/io_in_reader_debounce.sv
// debounce_bit: 2-FF synchroniser plus counter-based debouncer for one raw pin.
module debounce_bit #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             diff;
    logic             done;

    assign diff = sync[1] ^ level;
    assign done = diff && (cnt == CNT_W'(DB_CYCLES - 1));
    assign rise = done & sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            // any agreement or acceptance restarts the count, so it never wraps
            cnt  <= (diff && !done) ? cnt + 1'b1 : '0;
            if (done)
                level <= sync[1];
        end
    end
endmodule

// File: rtl/io_in_reader.sv
// io_in_reader: debounced switch/button input peripheral with sticky clear-on-read events.
module io_in_reader
    import io_pkg::*;
#(
    parameter int N_SW      = 16,
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw,
    input  logic [N_BTN-1:0] btn,
    io_in_reader_if.slave    bus
);
    logic [N_SW-1:0]  sw_lvl;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_BTN-1:0] btn_lvl;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] evt_nxt;
    logic             rd_evt;
    logic [31:0]      reg_val;

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .reset(reset), .pin(sw[g]), .level(sw_lvl[g]), .rise(sw_rise_unused[g])
        );
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .reset(reset), .pin(btn[g]), .level(btn_lvl[g]), .rise(btn_rise[g])
        );
    end

    always_comb begin
        rd_evt    = bus.cs & bus.rd & (bus.addr == IO_OFF_EVT);
        // an EVT read returns every bit of evt, so it clears all of them; same-cycle rises survive
        evt_nxt   = (rd_evt ? '0 : evt) | btn_rise;
        reg_val   = (bus.addr == IO_OFF_SW)  ? 32'(sw_lvl)  :
                    (bus.addr == IO_OFF_BTN) ? 32'(btn_lvl) :
                    (bus.addr == IO_OFF_EVT) ? 32'(evt)     : {30'b0, |evt, |btn_lvl};
        bus.rdata = (bus.cs & bus.rd) ? reg_val : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt         <= '0;
            bus.evt_irq <= 1'b0;
        end else begin
            evt         <= evt_nxt;
            bus.evt_irq <= |evt_nxt;
        end
    end
endmodule
